// File: rtl/complex_peak_detector.sv
// Magnitude-squared peak detector for the complex matched-filter output.
// Arms on a threshold crossing, then reports the largest |x|^2 and its index over a fixed window.
module complex_peak_detector #(
  parameter int unsigned DATA_WIDTH  = 21,
  parameter int unsigned MAG_WIDTH   = 2 * DATA_WIDTH,
  parameter int unsigned INDEX_WIDTH = 16,
  parameter int unsigned WINDOW      = 8
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         startFlag,
  input  logic                         stopFlag,
  input  logic                         dataValid,
  input  logic signed [DATA_WIDTH-1:0] dataInI,
  input  logic signed [DATA_WIDTH-1:0] dataInQ,
  input  logic        [MAG_WIDTH-1:0]  threshold,
  output logic        [MAG_WIDTH-1:0]  magOut,
  output logic                         magValid,
  output logic        [MAG_WIDTH-1:0]  peakMag,
  output logic        [INDEX_WIDTH-1:0] peakIndex,
  output logic                         peakValid,
  output logic                         busy
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned WIN_W  = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_SEARCH = 2'd2,
    S_REPORT = 2'd3
  } state_e;

  // Magnitude pipeline: stage 1 squares, stage 2 sums.
  logic signed [PROD_W-1:0]    sq_i_c;
  logic signed [PROD_W-1:0]    sq_q_c;
  logic        [PROD_W-1:0]    sq_i_q;
  logic        [PROD_W-1:0]    sq_q_q;
  logic                        vld1_q;
  logic        [MAG_WIDTH-1:0] mag_d;
  logic        [MAG_WIDTH-1:0] mag_q;
  logic                        mag_vld_q;

  assign sq_i_c = PROD_W'(dataInI) * PROD_W'(dataInI);
  assign sq_q_c = PROD_W'(dataInQ) * PROD_W'(dataInQ);
  assign mag_d  = MAG_WIDTH'(sq_i_q) + MAG_WIDTH'(sq_q_q);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sq_i_q    <= '0;
      sq_q_q    <= '0;
      vld1_q    <= 1'b0;
      mag_q     <= '0;
      mag_vld_q <= 1'b0;
    end else begin
      sq_i_q    <= $unsigned(sq_i_c);
      sq_q_q    <= $unsigned(sq_q_c);
      vld1_q    <= dataValid;
      mag_q     <= mag_d;
      mag_vld_q <= vld1_q;
    end
  end

  // Search FSM and its datapath registers.
  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [MAG_WIDTH-1:0]   peak_mag_q, peak_mag_d;
  logic [INDEX_WIDTH-1:0] peak_idx_q, peak_idx_d;
  logic                   peak_vld_q, peak_vld_d;
  logic                   busy_q, busy_d;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      win_q      <= '0;
      peak_mag_q <= '0;
      peak_idx_q <= '0;
      peak_vld_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      peak_mag_q <= peak_mag_d;
      peak_idx_q <= peak_idx_d;
      peak_vld_q <= peak_vld_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    peak_mag_d = peak_mag_q;
    peak_idx_d = peak_idx_q;
    peak_vld_d = 1'b0;

    // Index is the pre-increment count; IDLE does not count.
    if (state_q != S_IDLE && mag_vld_q) begin
      cnt_d = cnt_q + INDEX_WIDTH'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (stopFlag) begin
          state_d = S_IDLE;
        end else if (startFlag) begin
          state_d = S_ARMED;
          cnt_d   = '0;
        end
      end
      S_ARMED: begin
        if (stopFlag) begin
          state_d = S_IDLE;
        end else if (startFlag) begin
          cnt_d = '0;
        end else if (mag_vld_q && (mag_q > threshold)) begin
          peak_mag_d = mag_q;
          peak_idx_d = cnt_q;
          win_d      = WIN_W'(1);
          if (WINDOW == 1) begin
            state_d    = S_REPORT;
            peak_vld_d = 1'b1;
          end else begin
            state_d = S_SEARCH;
          end
        end
      end
      S_SEARCH: begin
        if (stopFlag) begin
          state_d = S_IDLE;
        end else if (mag_vld_q) begin
          win_d = win_q + WIN_W'(1);
          // Strict compare keeps the earliest sample on ties.
          if (mag_q > peak_mag_q) begin
            peak_mag_d = mag_q;
            peak_idx_d = cnt_q;
          end
          if (win_q == WIN_W'(WINDOW - 1)) begin
            state_d    = S_REPORT;
            peak_vld_d = 1'b1;
          end
        end
      end
      S_REPORT: begin
        state_d = stopFlag ? S_IDLE : S_ARMED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SEARCH) || (state_d == S_REPORT);
  end

  assign magOut    = mag_q;
  assign magValid  = mag_vld_q;
  assign peakMag   = peak_mag_q;
  assign peakIndex = peak_idx_q;
  assign peakValid = peak_vld_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_complex_peak_detector.sv
// Bench for complex_peak_detector: scoreboarded magnitude stream and peak reports,
// table-driven pipeline vectors and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_complex_peak_detector;

  localparam int unsigned DW  = 21;
  localparam int unsigned MW  = 42;
  localparam int unsigned IW  = 16;
  localparam int unsigned IW4 = 4;

  logic clock = 1'b0;
  logic resetN;
  always #5 clock = ~clock;

  logic                 startFlag, stopFlag, dataValid;
  logic signed [DW-1:0] dataInI, dataInQ;
  logic [MW-1:0]        threshold;
  logic [MW-1:0]        magOut, peakMag;
  logic                 magValid, peakValid, busy;
  logic [IW-1:0]        peakIndex;

  logic                 w_startFlag, w_stopFlag, w_dataValid;
  logic signed [DW-1:0] w_dataInI, w_dataInQ;
  logic [MW-1:0]        w_threshold;
  logic [MW-1:0]        w_magOut, w_peakMag;
  logic                 w_magValid, w_peakValid, w_busy;
  logic [IW4-1:0]       w_peakIndex;

  complex_peak_detector u_dut (
    .clock(clock), .resetN(resetN), .startFlag(startFlag), .stopFlag(stopFlag),
    .dataValid(dataValid), .dataInI(dataInI), .dataInQ(dataInQ), .threshold(threshold),
    .magOut(magOut), .magValid(magValid), .peakMag(peakMag), .peakIndex(peakIndex),
    .peakValid(peakValid), .busy(busy)
  );

  complex_peak_detector #(.INDEX_WIDTH(IW4), .WINDOW(1)) u_dut4 (
    .clock(clock), .resetN(resetN), .startFlag(w_startFlag), .stopFlag(w_stopFlag),
    .dataValid(w_dataValid), .dataInI(w_dataInI), .dataInQ(w_dataInQ), .threshold(w_threshold),
    .magOut(w_magOut), .magValid(w_magValid), .peakMag(w_peakMag), .peakIndex(w_peakIndex),
    .peakValid(w_peakValid), .busy(w_busy)
  );

  typedef struct packed {
    logic [MW-1:0] mag;
    logic [IW-1:0] idx;
  } peak_t;

  typedef struct {
    logic signed [DW-1:0] i;
    logic signed [DW-1:0] q;
    logic [MW-1:0]        mag;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int peak_cyc = -1;

  logic [MW-1:0] mag_exp_q[$];
  peak_t         peak_exp_q[$];
  logic [MW-1:0] m_exp;
  peak_t         p_exp;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [MW-1:0] model_mag(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q);
    longint li, lq;
    li = longint'(i);
    lq = longint'(q);
    return MW'(li * li + lq * lq);
  endfunction

  // Output monitor: every magValid / peakValid pops the oldest expectation.
  always @(negedge clock) begin
    if (resetN) begin
      if (magValid) begin
        if (mag_exp_q.size() == 0) check("mag_unexpected", 64'(magValid), 64'd0);
        else begin
          m_exp = mag_exp_q.pop_front();
          check("magOut", 64'(magOut), 64'(m_exp));
        end
      end
      if (peakValid) begin
        peak_cyc = cyc;
        if (peak_exp_q.size() == 0) check("peak_unexpected", 64'(peakValid), 64'd0);
        else begin
          p_exp = peak_exp_q.pop_front();
          check("peakMag", 64'(peakMag), 64'(p_exp.mag));
          check("peakIndex", 64'(peakIndex), 64'(p_exp.idx));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q, input logic [MW-1:0] exp);
    dataInI = i; dataInQ = q; dataValid = 1'b1;
    mag_exp_q.push_back(exp);
    tick();
    dataInI = '0; dataInQ = '0; dataValid = 1'b0;
  endtask

  task automatic feed(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q);
    drive(i, q, model_mag(i, q));
  endtask

  task automatic w_feed(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q);
    w_dataInI = i; w_dataInQ = q; w_dataValid = 1'b1;
    tick();
    w_dataInI = '0; w_dataInQ = '0; w_dataValid = 1'b0;
  endtask

  task automatic pulse_start();
    startFlag = 1'b1;
    tick();
    startFlag = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_magOut"},    64'(magOut),    64'd0);
    check({tag, "_magValid"},  64'(magValid),  64'd0);
    check({tag, "_peakMag"},   64'(peakMag),   64'd0);
    check({tag, "_peakIndex"}, 64'(peakIndex), 64'd0);
    check({tag, "_peakValid"}, 64'(peakValid), 64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  task automatic expect_drained(input string tag);
    check({tag, "_peak_pending"}, 64'(peak_exp_q.size()), 64'd0);
    check({tag, "_mag_pending"},  64'(mag_exp_q.size()),  64'd0);
  endtask

  vec_t tbl[8];
  logic signed [DW-1:0] vi, vq;
  int drv_cyc;
  logic got;

  initial begin
    tbl[0] = '{i: 21'sd3,        q: -21'sd4,       mag: 42'd25};
    tbl[1] = '{i: 21'sd1,        q: 21'sd1,        mag: 42'd2};
    tbl[2] = '{i: 21'sd2,        q: 21'sd0,        mag: 42'd4};
    tbl[3] = '{i: 21'sd0,        q: 21'sd0,        mag: 42'd0};
    tbl[4] = '{i: -21'sd1048576, q: -21'sd1048576, mag: 42'd2199023255552};
    tbl[5] = '{i: 21'sd1048575,  q: -21'sd1048576, mag: 42'd2199021158401};
    tbl[6] = '{i: -21'sd7,       q: 21'sd9,        mag: 42'd130};
    tbl[7] = '{i: 21'sd1048575,  q: 21'sd1048575,  mag: 42'd2199019061250};

    resetN = 1'b0;
    startFlag = 1'b0; stopFlag = 1'b0; dataValid = 1'b0;
    dataInI = '0; dataInQ = '0; threshold = '0;
    w_startFlag = 1'b0; w_stopFlag = 1'b0; w_dataValid = 1'b0;
    w_dataInI = '0; w_dataInQ = '0; w_threshold = '0;
    idle(3);
    check_all_zero("reset");
    resetN = 1'b1;
    idle(2);

    // Pipeline latency: (3,-4) appears exactly two edges later.
    dataInI = 21'sd3; dataInQ = -21'sd4; dataValid = 1'b1;
    mag_exp_q.push_back(42'd25);
    tick();
    dataInI = '0; dataInQ = '0; dataValid = 1'b0;
    @(negedge clock);
    check("pipe_early_vld", 64'(magValid), 64'd0);
    @(posedge clock);
    @(negedge clock);
    check("pipe_lat_vld", 64'(magValid), 64'd1);
    check("pipe_lat_mag", 64'(magOut), 64'd25);
    tick();

    // Back-to-back table vectors while IDLE; threshold 0 must not trigger a search.
    threshold = '0;
    for (int k = 0; k < 8; k++) drive(tbl[k].i, tbl[k].q, tbl[k].mag);
    idle(4);
    check("idle_busy", 64'(busy), 64'd0);
    expect_drained("table");

    // Single detection: crossing at 5, peak (0,6) at 7.
    threshold = 42'd10;
    pulse_start();
    peak_exp_q.push_back('{mag: 42'd36, idx: 16'd7});
    peak_cyc = -1;
    drv_cyc = 0;
    for (int k = 0; k < 16; k++) begin
      vi = '0; vq = '0;
      if (k == 5) begin vi = 21'sd3; vq = 21'sd4; end
      if (k == 7) begin vi = 21'sd0; vq = 21'sd6; end
      if (k == 3) check("det_busy_armed", 64'(busy), 64'd0);
      if (k == 8) check("det_busy_search", 64'(busy), 64'd1);
      if (k == 12) drv_cyc = cyc;
      feed(vi, vq);
    end
    idle(4);
    check("det_peak_cycle", 64'(peak_cyc), 64'(drv_cyc + 3));
    check("det_busy_after", 64'(busy), 64'd0);
    expect_drained("det");

    // Re-armed: counter kept running through REPORT, next crossing is index 16.
    peak_exp_q.push_back('{mag: 42'd16, idx: 16'd16});
    feed(21'sd0, 21'sd4);
    for (int k = 0; k < 7; k++) feed(21'sd0, 21'sd0);
    idle(6);
    expect_drained("rearm");

    // Tie at the extreme magnitude: earliest index wins.
    threshold = '0;
    pulse_start();
    peak_exp_q.push_back('{mag: 42'd2199023255552, idx: 16'd2});
    for (int k = 0; k < 12; k++) begin
      if (k == 2 || k == 4) feed(-21'sd1048576, -21'sd1048576);
      else feed(21'sd0, 21'sd0);
    end
    idle(6);
    expect_drained("tie");

    // Stop during SEARCH abandons the search.
    threshold = 42'd10;
    pulse_start();
    feed(21'sd0, 21'sd4);
    for (int k = 0; k < 3; k++) feed(21'sd0, 21'sd0);
    check("stop_busy_before", 64'(busy), 64'd1);
    stopFlag = 1'b1;
    tick();
    stopFlag = 1'b0;
    check("stop_busy_after", 64'(busy), 64'd0);
    for (int k = 0; k < 10; k++) feed(21'sd3, 21'sd4);
    idle(4);
    check("stop_idle_busy", 64'(busy), 64'd0);

    // Start and stop together: stays IDLE.
    startFlag = 1'b1; stopFlag = 1'b1;
    tick();
    startFlag = 1'b0; stopFlag = 1'b0;
    feed(21'sd3, 21'sd4);
    for (int k = 0; k < 9; k++) feed(21'sd0, 21'sd0);
    idle(4);
    check("startstop_busy", 64'(busy), 64'd0);
    expect_drained("stop");

    // A plain start recovers.
    pulse_start();
    peak_exp_q.push_back('{mag: 42'd25, idx: 16'd0});
    feed(21'sd3, 21'sd4);
    for (int k = 0; k < 8; k++) feed(21'sd0, 21'sd0);
    idle(5);
    expect_drained("recover");

    // Async reset mid-search: outputs clear within the cycle, no report.
    pulse_start();
    feed(21'sd0, 21'sd4);
    for (int k = 0; k < 3; k++) feed(21'sd0, 21'sd0);
    #2;
    resetN = 1'b0;
    #1;
    check_all_zero("async_rst");
    mag_exp_q.delete();
    tick();
    resetN = 1'b1;
    idle(2);
    pulse_start();
    peak_exp_q.push_back('{mag: 42'd50, idx: 16'd0});
    feed(21'sd5, 21'sd5);
    for (int k = 0; k < 7; k++) feed(21'sd0, 21'sd0);
    idle(6);
    expect_drained("post_rst");

    // Index wrap on the 4-bit, single-sample-window instance: 18th sample -> index 1.
    w_threshold = 42'd10;
    w_startFlag = 1'b1;
    tick();
    w_startFlag = 1'b0;
    drv_cyc = 0;
    for (int k = 0; k < 18; k++) begin
      if (k == 17) begin
        drv_cyc = cyc;
        w_feed(21'sd0, 21'sd4);
      end else begin
        w_feed(21'sd0, 21'sd0);
      end
    end
    got = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      if (w_peakValid) begin
        got = 1'b1;
        check("wrap_peakMag", 64'(w_peakMag), 64'd16);
        check("wrap_peakIndex", 64'(w_peakIndex), 64'd1);
        check("wrap_cycle", 64'(cyc), 64'(drv_cyc + 3));
        break;
      end
    end
    check("wrap_seen", 64'(got), 64'd1);
    idle(2);
    check("wrap_busy", 64'(w_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/complex_peak_detector.md
Name: complex_peak_detector

Overview:
- Sits directly downstream of the complex FIR (matched filter) and consumes its dataOutI/dataOutQ stream.
- Computes |x|² = I² + Q² per valid sample and arms against a threshold.
- After a threshold crossing, searches a fixed window of samples for the maximum and reports its magnitude and sample index.
- Output feeds the range/target reporting logic.

Parameters:
- DATA_WIDTH, 21, signed width of dataInI/dataInQ (matches FIR output width).
- MAG_WIDTH, 2*DATA_WIDTH, unsigned width of magnitude-squared; 42 bits holds the worst case 2^41.
- INDEX_WIDTH, 16, width of the sample index counter.
- WINDOW, 8, number of magnitude samples examined per search, including the crossing sample; must be ≥1.

Ports:
- clock, input, 1: single clock; all logic on posedge.
- resetN, input, 1: asynchronous, active-low reset.
- startFlag, input, 1: 1-cycle pulse; clears the index counter and enters ARMED.
- stopFlag, input, 1: returns to IDLE and discards any search in progress.
- dataValid, input, 1: dataInI/dataInQ are valid this cycle.
- dataInI, input, DATA_WIDTH signed: in-phase FIR output.
- dataInQ, input, DATA_WIDTH signed: quadrature FIR output.
- threshold, input, MAG_WIDTH unsigned: detection threshold; sampled each compare.
- magOut, output, MAG_WIDTH unsigned: registered I²+Q² of every valid sample.
- magValid, output, 1: magOut valid.
- peakMag, output, MAG_WIDTH unsigned: maximum magnitude in the last completed window.
- peakIndex, output, INDEX_WIDTH: sample index of peakMag.
- peakValid, output, 1: 1-cycle pulse; peakMag and peakIndex are valid.
- busy, output, 1: high in SEARCH or REPORT.

Behaviour:
- Reset (resetN=0, async):
  - All outputs are 0.
  - State is IDLE; sampleCounter, windowCount, pipeline registers and valid flags are 0.
  - Reset in any state, including mid-search, abandons the search with no peakValid.
- Magnitude pipeline (runs in every state):
  - Stage 1 registers I*I and Q*Q, each an unsigned 2*DATA_WIDTH-bit result.
  - Stage 2 registers the sum into magOut.
  - magValid is dataValid delayed 2 cycles. Latency is fixed at 2 cycles; full throughput, one sample per clock.
  - No saturation is needed: (-2^20)² + (-2^20)² = 2^41 fits in 42 bits.
- sampleCounter:
  - Increments on each magValid, in all states except IDLE.
  - Cleared to 0 by startFlag.
  - Wraps modulo 2^INDEX_WIDTH.
  - The index of a sample is the counter value before its increment, so the first sample after start has index 0.
- FSM, with stopFlag checked first in every state (stopFlag overrides startFlag when both are high):
  - IDLE: on startFlag go to ARMED and clear sampleCounter. Incoming samples are ignored and not counted.
  - ARMED: on magValid with magOut > threshold (strictly greater), load peakMag=magOut, peakIndex=current index, windowCount=1, then go to SEARCH. If WINDOW==1, go straight to REPORT. A startFlag here re-clears the counter.
  - SEARCH: on each magValid, windowCount increments. If magOut > peakMag (strictly), update peakMag and peakIndex, so on ties the earliest sample is kept. When windowCount reaches WINDOW, go to REPORT. The threshold is not re-checked here.
  - REPORT: peakValid=1 for exactly one cycle, then go to ARMED. A magValid arriving during REPORT is counted but not compared.
- peakMag and peakIndex hold their values until the next search loads them, and remain readable after peakValid.
- Any startFlag in SEARCH or REPORT is ignored.

Test Plan:
- Reset: drive resetN=0 mid-stream → all outputs 0 within the same cycle (async). Release and pulse startFlag → first valid sample carries index 0.
- Pipeline: dataInI=3, dataInQ=-4, dataValid=1 at cycle t → magOut=25, magValid=1 at t+2. Back-to-back samples (1,1),(2,0) → magOut 2 then 4 on consecutive cycles.
- Single detection:
  - Setup: threshold=10, WINDOW=8; after start, feed zeros except index 5=(3,4) and index 7=(0,6).
  - Required: crossing at index 5.
  - Required: peakMag=36, peakIndex=7, peakValid pulses once, 2 cycles after index 12's input cycle, plus the one REPORT cycle.
  - Required: FSM returns to ARMED.
- Tie and extreme: index 2=(-1048576,-1048576) and index 4 identical, threshold=0 → peakMag=2199023255552 (2^41), peakIndex=2.
- Stop mid-search:
  - Stimulus: stopFlag asserted during SEARCH.
  - Required: no peakValid, busy=0 the next cycle, state IDLE, further samples not counted.
  - Required: startFlag and stopFlag asserted together → stays IDLE.
- Counter wrap: INDEX_WIDTH=4 with a crossing at the 18th sample → peakIndex=1.
